// File: rtl/row_accumulator.sv
// Row accumulator: sums ROWS row-filter results plus bias, then applies ReLU, rounding shift and saturation.
// The finished pixel sits in one holding register behind a valid/ready handshake.
module row_accumulator #(
  parameter int BITWIDTH  = 8,
  parameter int ROWS      = 3,
  parameter int ACC_GUARD = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              row_valid,
  input  logic [2*BITWIDTH-1:0]             row_sum,
  input  logic [2*BITWIDTH-1:0]             bias,
  input  logic [$clog2(2*BITWIDTH)-1:0]     shift,
  input  logic                              relu_en,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BITWIDTH-1:0]               dout,
  output logic [$clog2(ROWS):0]             row_idx,
  output logic                              overrun
);

  localparam int AW = 2*BITWIDTH + ACC_GUARD;
  localparam int SW = $clog2(2*BITWIDTH);
  localparam int IW = $clog2(ROWS) + 1;
  localparam logic signed [AW:0] MAXV = (AW+1)'((2**(BITWIDTH-1)) - 1);
  localparam logic signed [AW:0] MINV = -(AW+1)'(2**(BITWIDTH-1));

  // ReLU, round-half-up arithmetic shift, then clamp to the output range.
  function automatic logic [BITWIDTH-1:0] requant(input logic signed [AW-1:0] t,
                                                  input logic [SW-1:0] sh,
                                                  input logic relu);
    logic signed [AW:0] r;
    logic signed [AW:0] rnd;
    r = (relu && t[AW-1]) ? '0 : (AW+1)'(t);
    if (sh != '0) begin
      rnd = (AW+1)'(1) << (sh - 1'b1);
      r   = (r + rnd) >>> sh;
    end
    if (r > MAXV)      r = MAXV;
    else if (r < MINV) r = MINV;
    return r[BITWIDTH-1:0];
  endfunction

  logic signed [AW-1:0] acc_q, acc_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 vld_q, vld_d;
  logic [BITWIDTH-1:0]  dout_q, dout_d;
  logic                 ovr_q, ovr_d;

  logic signed [AW-1:0] row_ext, bias_ext, total;
  logic                 first_row, last_row, complete;

  assign row_ext   = {{(AW-2*BITWIDTH){row_sum[2*BITWIDTH-1]}}, row_sum};
  assign bias_ext  = {{(AW-2*BITWIDTH){bias[2*BITWIDTH-1]}}, bias};
  assign first_row = (idx_q == '0);
  assign last_row  = (idx_q == IW'(ROWS-1));
  // With ROWS=1 a row is both first and last, so the bias still enters the total.
  assign total     = (first_row ? bias_ext : acc_q) + row_ext;
  assign complete  = row_valid && !clear && last_row;

  always_comb begin
    acc_d  = acc_q;
    idx_d  = idx_q;
    vld_d  = vld_q;
    dout_d = dout_q;
    ovr_d  = ovr_q;
    if (clear) begin
      acc_d = '0;
      idx_d = '0;
      ovr_d = 1'b0;
    end else if (row_valid) begin
      if (last_row) begin
        acc_d = '0;
        idx_d = '0;
      end else begin
        acc_d = total;
        idx_d = idx_q + 1'b1;
      end
    end
    if (complete) begin
      if (!vld_q || out_ready) begin
        dout_d = requant(total, shift, relu_en);
        vld_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (vld_q && out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q  <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      dout_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      idx_q  <= idx_d;
      vld_q  <= vld_d;
      dout_q <= dout_d;
      ovr_q  <= ovr_d;
    end
  end

  assign out_valid = vld_q;
  assign dout      = dout_q;
  assign row_idx   = idx_q;
  assign overrun   = ovr_q;

endmodule
